// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller:
// state encodings, the canonical NOP and a saturating increment helper.
package pipe_ctrl_pkg;

  localparam logic [1:0]  PIPE_RUN     = 2'd0;
  localparam logic [1:0]  PIPE_FLUSH   = 2'd1;
  localparam logic [1:0]  PIPE_EX_HOLD = 2'd2;

  // addi x0, x0, 0 -- what the pipeline registers load on a flush
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN     = PIPE_RUN,
    ST_FLUSH   = PIPE_FLUSH,
    ST_EX_HOLD = PIPE_EX_HOLD
  } pipe_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/control bundle between the execute/decode stages, the pipeline
// registers and pipe_ctrl. master = pipeline side, slave = controller.
interface pipe_ctrl_if;

  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        load_use_i;
  logic        hold_req_i;
  logic        hold_done_i;

  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic        pc_hold_o;
  logic        if_id_hold_o;
  logic        if_id_flush_o;
  logic        id_ex_hold_o;
  logic        id_ex_flush_o;
  logic        hold_err_o;
  logic [31:0] stall_cnt_o;

  modport master (
    output jump_en_i, jump_addr_i, load_use_i, hold_req_i, hold_done_i,
    input  jump_en_o, jump_addr_o, pc_hold_o, if_id_hold_o, if_id_flush_o,
           id_ex_hold_o, id_ex_flush_o, hold_err_o, stall_cnt_o
  );

  modport slave (
    input  jump_en_i, jump_addr_i, load_use_i, hold_req_i, hold_done_i,
    output jump_en_o, jump_addr_o, pc_hold_o, if_id_hold_o, if_id_flush_o,
           id_ex_hold_o, id_ex_flush_o, hold_err_o, stall_cnt_o
  );

endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: arbitrates redirects, execute holds and
// load-use bubbles into hold/flush controls for PC, if_id and id_ex.
// Control outputs are Mealy so a flush lands on the same edge as its cause.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int HOLD_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_ctrl_if.slave ctl
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int HC_W = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [HC_W-1:0] HOLD_MAX   = HC_W'(HOLD_TIMEOUT);

  pipe_state_e      state_q, state_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic             hold_err_q, hold_err_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;

  logic do_jump, do_hold, do_lu;
  logic jump_en, pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush;

  // Registered state and counters; reset returns to RUN with everything cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      hold_cnt_q  <= '0;
      hold_err_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_err_q  <= hold_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state and Mealy controls; priority is jump > execute hold > load-use.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    hold_err_d  = hold_err_q;
    do_jump     = 1'b0;
    do_hold     = 1'b0;
    do_lu       = 1'b0;
    jump_en     = 1'b0;
    pc_hold     = 1'b0;
    if_id_hold  = 1'b0;
    if_id_flush = 1'b0;
    id_ex_hold  = 1'b0;
    id_ex_flush = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (ctl.jump_en_i)       do_jump = 1'b1;
        else if (ctl.hold_req_i) do_hold = 1'b1;
        else if (ctl.load_use_i) do_lu   = 1'b1;
      end
      ST_FLUSH: begin
        // Decode holds a NOP here, so load-use is meaningless and ignored.
        if (ctl.jump_en_i) begin
          do_jump = 1'b1;
        end else begin
          if_id_flush = 1'b1;
          if (ctl.hold_req_i) begin
            do_hold = 1'b1;
          end else begin
            flush_cnt_d = flush_cnt_q - FC_W'(1);
            if (flush_cnt_q <= FC_W'(1)) state_d = ST_RUN;
          end
        end
      end
      ST_EX_HOLD: begin
        if (ctl.jump_en_i) begin
          do_jump = 1'b1;
        end else if (ctl.hold_done_i || hold_cnt_q == HOLD_MAX) begin
          // Release cycle: execute advances, so a pending load-use still applies.
          state_d    = ST_RUN;
          hold_cnt_d = '0;
          if (!ctl.hold_done_i) hold_err_d = 1'b1;
          if (ctl.load_use_i) do_lu = 1'b1;
        end else begin
          pc_hold    = 1'b1;
          if_id_hold = 1'b1;
          id_ex_hold = 1'b1;
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (do_jump) begin
      jump_en     = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      flush_cnt_d = FLUSH_LOAD;
      hold_cnt_d  = '0;
      state_d     = (FLUSH_LOAD != '0) ? ST_FLUSH : ST_RUN;
    end
    if (do_hold) begin
      pc_hold    = 1'b1;
      if_id_hold = 1'b1;
      id_ex_hold = 1'b1;
      hold_cnt_d = HC_W'(1);
      state_d    = ST_EX_HOLD;
    end
    if (do_lu) begin
      pc_hold     = 1'b1;
      if_id_hold  = 1'b1;
      id_ex_flush = 1'b1;
    end

    stall_cnt_d = pc_hold ? sat_inc32(stall_cnt_q) : stall_cnt_q;
  end

  // A flush overrides a hold on the same register.
  assign ctl.jump_en_o     = jump_en;
  assign ctl.jump_addr_o   = jump_en ? ctl.jump_addr_i : 32'd0;
  assign ctl.pc_hold_o     = pc_hold;
  assign ctl.if_id_hold_o  = if_id_hold & ~if_id_flush;
  assign ctl.if_id_flush_o = if_id_flush;
  assign ctl.id_ex_hold_o  = id_ex_hold & ~id_ex_flush;
  assign ctl.id_ex_flush_o = id_ex_flush;
  assign ctl.hold_err_o    = hold_err_q;
  assign ctl.stall_cnt_o   = stall_cnt_q;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the RV32I five-stage core. Collects redirect and hazard requests from the execute and decode stages and drives the hold/flush controls of the PC register, `if_id` and `id_ex`. Also covers the multi-cycle refetch penalty after a taken jump or branch, and multi-cycle execute holds with a watchdog. Sits beside the pipeline registers and is the only source of their hold/flush inputs.

## Interface
- `FLUSH_CYCLES`, default 2: cycles `if_id` is flushed after a redirect (≥1). Covers the instruction-ROM read latency.
- `HOLD_TIMEOUT`, default 64: maximum cycles of an execute hold before forced release (≥2).
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `jump_en_i`  in  1  execute stage: taken branch or `jal` this cycle.
- `jump_addr_i`  in  32  redirect target.
- `load_use_i`  in  1  decode stage: rs1/rs2 depend on a load currently in execute.
- `hold_req_i`  in  1  execute stage: multi-cycle operation started.
- `hold_done_i`  in  1  execute stage: multi-cycle operation completes this cycle.
- `jump_en_o`  out  1  redirect to PC register.
- `jump_addr_o`  out  32  redirect target to PC register.
- `pc_hold_o`  out  1  freeze PC.
- `if_id_hold_o`  out  1  freeze `if_id`.
- `if_id_flush_o`  out  1  load NOP (0x00000013) into `if_id`.
- `id_ex_hold_o`  out  1  freeze `id_ex`.
- `id_ex_flush_o`  out  1  load NOP into `id_ex`.
- `hold_err_o`  out  1  sticky: watchdog fired.
- `stall_cnt_o`  out  32  saturating count of cycles with `pc_hold_o`=1.

## Operation
- FSM states: `RUN`, `FLUSH`, `EX_HOLD`. Reset state is `RUN`.
- Priority, evaluated in every state: `jump_en_i` > execute hold > `load_use_i`.
- `RUN`:
  - `jump_en_i`: outputs `jump_en_o`=1, `jump_addr_o`=`jump_addr_i`, `if_id_flush_o`=1, `id_ex_flush_o`=1. Loads `flush_cnt`=`FLUSH_CYCLES`-1. Goes to `FLUSH` if that value is non-zero, else stays in `RUN`.
  - else `hold_req_i`: `pc_hold_o`, `if_id_hold_o`, `id_ex_hold_o`=1. Loads `hold_cnt`=1. Goes to `EX_HOLD`.
  - else `load_use_i`: `pc_hold_o`=1, `if_id_hold_o`=1, `id_ex_flush_o`=1 for that cycle only (one bubble). Stays in `RUN`.
- `FLUSH`: `if_id_flush_o`=1 and `flush_cnt` decrements. Goes to `RUN` when `flush_cnt` reaches 1. `load_use_i` is ignored, since the decode slot is a NOP. A new `jump_en_i` re-enters the `RUN` jump action and reloads the counter.
- `EX_HOLD`: all three holds asserted and `hold_cnt` increments.
  - `hold_done_i`: holds deassert this same cycle; go to `RUN`.
  - `hold_cnt`=`HOLD_TIMEOUT`: treated as `hold_done_i`, and `hold_err_o` is set.
  - `jump_en_i` while in `EX_HOLD`: jump action, go to `FLUSH`/`RUN`, hold abandoned.
- Hold and flush on the same register: flush wins (`id_ex_flush_o`=1 forces `id_ex_hold_o`=0).
- `jump_addr_o` is 0 whenever `jump_en_o`=0.
- `stall_cnt_o` increments in every cycle where `pc_hold_o`=1 and saturates at 0xFFFFFFFF.

## Timing
- All pipeline control outputs are Mealy. They are combinational from the inputs plus the registered state, with zero latency, so that the flush lands on the same edge as the redirect.
- State, `flush_cnt`, `hold_cnt`, `hold_err_o` and `stall_cnt_o` are registered on `clk` rising edge.
- Redirect penalty: `FLUSH_CYCLES` bubbles in `if_id` plus 1 in `id_ex`.
- Reset (async, any state, mid-hold or mid-flush): state=`RUN`, counters=0, `hold_err_o`=0, `stall_cnt_o`=0. With all inputs low, every control output is 0.
- `hold_err_o` clears only on reset.

## Structure
- Shared core defines file: add `PIPE_RUN`/`PIPE_FLUSH`/`PIPE_EX_HOLD` state encodings (2 bits) and `INST_NOP` (32'h00000013) if not already present.
- Single module; no sub-module. The saturating counter is inline.

## Test plan
- Reset with `FLUSH_CYCLES`=2, then `jump_en_i`=1 for one cycle, `jump_addr_i`=0x100 → cycle 0: `jump_en_o`=1, `jump_addr_o`=0x100, both flushes=1. Cycle 1: `if_id_flush_o`=1 only. Cycle 2: all 0.
- `load_use_i`=1 for one cycle in `RUN` → `pc_hold_o`=`if_id_hold_o`=`id_ex_flush_o`=1, `id_ex_hold_o`=0. `stall_cnt_o` goes 0→1.
- `hold_req_i`, then `hold_done_i` 5 cycles later → holds high for cycles 0–4, low in cycle 5 (the done cycle). `stall_cnt_o`=5. `hold_err_o`=0.
- `HOLD_TIMEOUT`=8, `hold_req_i` with no done → forced release after cycle 7. `hold_err_o`=1 and stays set; a later normal hold still works.
- `jump_en_i`, `hold_req_i` and `load_use_i` all high in the same cycle → jump action only; state `FLUSH`; no hold asserted.
- `rst_n` low asynchronously mid-`EX_HOLD` → all outputs 0 before the next edge; state `RUN` after release.
